// File: rtl/spi_shift_engine.sv
// SPI master shift engine: generates CS_N/SCLK for the latched mode and rate,
// shifts the low N bits of the ordered TX word out MSB-first and captures N bits of MISO.
module spi_shift_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SPI_START,
  input  logic [1:0]            SPI_DATA_LEN,
  input  logic [DATA_WIDTH-1:0] SPI_DATA_IN,
  input  logic                  SPI_CPOL,
  input  logic                  SPI_CPHA,
  input  logic [DIV_WIDTH-1:0]  SPI_CLK_DIV,
  input  logic                  SPI_MISO,
  output logic                  SPI_SCLK,
  output logic                  SPI_MOSI,
  output logic                  SPI_CS_N,
  output logic                  SPI_BUSY,
  output logic                  SPI_DONE,
  output logic [DATA_WIDTH-1:0] SPI_RX_DATA
);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic [5:0]            len_q, len_d, bit_cnt_q, bit_cnt_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic [31:0]           tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, rx_data_q, rx_data_d;
  logic                  sclk_q, sclk_d, mosi_q, mosi_d;

  logic                  tick, lead_edge, sample, last, drive;
  logic [5:0]            len_in;
  logic [31:0]           tx_aligned;

  always_comb begin
    len_in = 6'd32;
    tx_aligned = SPI_DATA_IN[31:0];
    case (SPI_DATA_LEN)
      2'b00: begin len_in = 6'd24; tx_aligned = {SPI_DATA_IN[23:0], 8'h0};  end
      2'b01: begin len_in = 6'd16; tx_aligned = {SPI_DATA_IN[15:0], 16'h0}; end
      2'b10: begin len_in = 6'd8;  tx_aligned = {SPI_DATA_IN[7:0], 24'h0};  end
      default: ;
    endcase
  end

  // Leading edge = SCLK leaving its idle level; CPHA picks which edge samples.
  assign tick      = (cnt_q == div_q);
  assign lead_edge = (sclk_q == cpol_q);
  assign sample    = (lead_edge != cpha_q);
  assign last      = !lead_edge && ((bit_cnt_q + {5'd0, sample}) == len_q);
  assign drive     = cpha_q ? lead_edge : (!lead_edge && !last);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    case (state_q)
      S_IDLE: begin
        sclk_d = SPI_CPOL;
        if (SPI_START) begin
          state_d   = S_LEAD;
          div_d     = SPI_CLK_DIV;
          cnt_d     = '0;
          len_d     = len_in;
          bit_cnt_d = '0;
          cpol_d    = SPI_CPOL;
          cpha_d    = SPI_CPHA;
          rx_d      = '0;
          if (SPI_CPHA) begin
            tx_d = tx_aligned;
          end else begin
            // CPHA=0 needs the first bit on the wire before the first edge.
            mosi_d = tx_aligned[31];
            tx_d   = {tx_aligned[30:0], 1'b0};
          end
        end
      end
      S_LEAD, S_SHIFT: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          sclk_d = ~sclk_q;
          if (sample) begin
            rx_d      = {rx_q[DATA_WIDTH-2:0], SPI_MISO};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
          if (drive) begin
            mosi_d = tx_q[31];
            tx_d   = {tx_q[30:0], 1'b0};
          end
          if (state_q == S_LEAD) state_d = S_SHIFT;
          else if (last)         state_d = S_TRAIL;
        end
      end
      S_TRAIL: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          state_d   = S_DONE;
          rx_data_d = rx_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
    end
  end

  assign SPI_SCLK    = sclk_q;
  assign SPI_MOSI    = mosi_q;
  assign SPI_CS_N    = !(state_q == S_LEAD || state_q == S_SHIFT || state_q == S_TRAIL);
  assign SPI_BUSY    = (state_q != S_IDLE);
  assign SPI_DONE    = (state_q == S_DONE);
  assign SPI_RX_DATA = rx_data_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: watches the serial pins each cycle and checks
// timing, bit streams and the received word against a wire-level model.
module tb_spi_shift_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SPI_START = 1'b0;
  logic [1:0]  SPI_DATA_LEN = 2'b10;
  logic [31:0] SPI_DATA_IN = '0;
  logic        SPI_CPOL = 1'b0, SPI_CPHA = 1'b0;
  logic [7:0]  SPI_CLK_DIV = '0;
  logic        SPI_MISO;
  logic        SPI_SCLK, SPI_MOSI, SPI_CS_N, SPI_BUSY, SPI_DONE;
  logic [31:0] SPI_RX_DATA;

  logic        loop_en = 1'b1;
  logic        miso_drv = 1'b0;
  assign SPI_MISO = loop_en ? SPI_MOSI : miso_drv;

  int n_cmp = 0, n_err = 0;

  spi_shift_engine #(.DATA_WIDTH(32), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .SPI_START(SPI_START), .SPI_DATA_LEN(SPI_DATA_LEN),
    .SPI_DATA_IN(SPI_DATA_IN), .SPI_CPOL(SPI_CPOL), .SPI_CPHA(SPI_CPHA),
    .SPI_CLK_DIV(SPI_CLK_DIV), .SPI_MISO(SPI_MISO), .SPI_SCLK(SPI_SCLK),
    .SPI_MOSI(SPI_MOSI), .SPI_CS_N(SPI_CS_N), .SPI_BUSY(SPI_BUSY),
    .SPI_DONE(SPI_DONE), .SPI_RX_DATA(SPI_RX_DATA)
  );

  always #5 clk = ~clk;

  // Observations of the last transfer
  int          o_cs_low, o_edges, o_first, o_min_h, o_max_h, o_lat, o_done;
  logic [31:0] o_mosi, o_miso, o_rx;
  logic        o_busy_d, o_csn_d, o_mosi_d, o_sclk_d;

  function automatic int len_n(input logic [1:0] l);
    case (l)
      2'b00: return 24;
      2'b01: return 16;
      2'b10: return 8;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] low_bits(input logic [31:0] d, input int n);
    logic [31:0] m;
    m = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    return d & m;
  endfunction

  // Launches one transfer and records what appears on the pins until DONE.
  task automatic run_xfer(input logic [1:0] len, input logic [31:0] data,
                          input logic cpol, input logic cpha, input logic [7:0] div,
                          input logic loop, input int inj_cyc, input bit start_at_done,
                          input bit no_wait);
    int budget, last_t;
    logic prev;
    if (!no_wait) @(negedge clk);
    SPI_DATA_LEN = len; SPI_DATA_IN = data; SPI_CPOL = cpol; SPI_CPHA = cpha;
    SPI_CLK_DIV = div; loop_en = loop;
    if (!no_wait) @(negedge clk);
    SPI_START = 1'b1;
    prev = SPI_SCLK;
    budget = (2 * len_n(len) + 1) * (int'(div) + 1) + 20;
    o_cs_low = 0; o_edges = 0; o_first = 0; o_min_h = 1 << 30; o_max_h = 0;
    o_lat = -1; o_done = 0; o_mosi = '0; o_miso = '0; last_t = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) SPI_START = 1'b0;
      if (c == inj_cyc) begin
        SPI_START = 1'b1; SPI_DATA_IN = $urandom; SPI_DATA_LEN = 2'($urandom);
        SPI_CPHA = ~cpha; SPI_CLK_DIV = 8'($urandom);
      end
      if (c == inj_cyc + 1) SPI_START = 1'b0;
      if (!SPI_CS_N) o_cs_low++;
      if (SPI_SCLK !== prev) begin
        o_edges++;
        if (o_edges == 1) o_first = c;
        else begin
          if (c - last_t < o_min_h) o_min_h = c - last_t;
          if (c - last_t > o_max_h) o_max_h = c - last_t;
        end
        last_t = c;
        if ((SPI_SCLK != cpol) == !cpha) begin
          o_mosi = {o_mosi[30:0], SPI_MOSI};
          o_miso = {o_miso[30:0], SPI_MISO};
        end
      end
      prev = SPI_SCLK;
      miso_drv = 1'($urandom);
      if (SPI_DONE) begin
        o_done++; o_lat = c; o_rx = SPI_RX_DATA; o_busy_d = SPI_BUSY;
        o_csn_d = SPI_CS_N; o_mosi_d = SPI_MOSI; o_sclk_d = SPI_SCLK;
        if (start_at_done) SPI_START = 1'b1;
        break;
      end
    end
    SPI_DATA_LEN = len; SPI_DATA_IN = data; SPI_CPHA = cpha; SPI_CLK_DIV = div;
  endtask

  task automatic test_reset();
    #23;
    n_cmp++; if ({SPI_SCLK, SPI_MOSI, SPI_CS_N, SPI_BUSY, SPI_DONE} !== 5'b00100) begin
      n_err++; $display("FAIL reset_pins got %b want 00100", {SPI_SCLK, SPI_MOSI, SPI_CS_N, SPI_BUSY, SPI_DONE}); end
    n_cmp++; if (SPI_RX_DATA !== 32'h0) begin
      n_err++; $display("FAIL reset_rx got %h want 0", SPI_RX_DATA); end
    @(negedge clk); rst = 1'b0; SPI_CPOL = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({SPI_SCLK, SPI_CS_N, SPI_BUSY} !== 3'b110) begin
      n_err++; $display("FAIL idle_cpol1 got %b want 110", {SPI_SCLK, SPI_CS_N, SPI_BUSY}); end
    SPI_CPOL = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (SPI_SCLK !== 1'b0) begin
      n_err++; $display("FAIL idle_cpol0 got %b want 0", SPI_SCLK); end
  endtask

  task automatic test_mode0();
    run_xfer(2'b10, 32'h0000_00A5, 1'b0, 1'b0, 8'd0, 1'b1, -5, 1'b0, 1'b0);
    n_cmp++; if (o_mosi[7:0] !== 8'hA5) begin
      n_err++; $display("FAIL m0_mosi got %h want a5", o_mosi[7:0]); end
    n_cmp++; if (o_cs_low !== 17 || o_edges !== 16) begin
      n_err++; $display("FAIL m0_timing got cs=%0d edges=%0d want 17/16", o_cs_low, o_edges); end
    n_cmp++; if (o_lat !== 18 || o_done !== 1) begin
      n_err++; $display("FAIL m0_done got lat=%0d n=%0d want 18/1", o_lat, o_done); end
    n_cmp++; if (o_rx !== 32'hA5) begin
      n_err++; $display("FAIL m0_rx got %h want a5", o_rx); end
    n_cmp++; if ({o_busy_d, o_csn_d, o_mosi_d, o_sclk_d} !== 4'b1110) begin
      n_err++; $display("FAIL m0_done_pins got %b want 1110", {o_busy_d, o_csn_d, o_mosi_d, o_sclk_d}); end
    @(negedge clk);
    n_cmp++; if (SPI_DONE !== 1'b0 || SPI_BUSY !== 1'b0) begin
      n_err++; $display("FAIL m0_done_width got done=%b busy=%b want 0/0", SPI_DONE, SPI_BUSY); end
    repeat (5) @(negedge clk);
    n_cmp++; if (SPI_RX_DATA !== 32'hA5 || SPI_MOSI !== 1'b1) begin
      n_err++; $display("FAIL m0_hold got rx=%h mosi=%b want a5/1", SPI_RX_DATA, SPI_MOSI); end
  endtask

  task automatic test_mode3();
    SPI_CPOL = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (SPI_SCLK !== 1'b1) begin
      n_err++; $display("FAIL m3_idle got %b want 1", SPI_SCLK); end
    run_xfer(2'b01, 32'h1234_BEEF, 1'b1, 1'b1, 8'd3, 1'b1, -5, 1'b0, 1'b0);
    n_cmp++; if (o_cs_low !== 132 || o_edges !== 32) begin
      n_err++; $display("FAIL m3_timing got cs=%0d edges=%0d want 132/32", o_cs_low, o_edges); end
    n_cmp++; if (o_first !== 5 || o_min_h !== 4 || o_max_h !== 4) begin
      n_err++; $display("FAIL m3_half got first=%0d min=%0d max=%0d want 5/4/4", o_first, o_min_h, o_max_h); end
    n_cmp++; if (o_rx !== 32'h0000_BEEF || o_mosi[15:0] !== 16'hBEEF) begin
      n_err++; $display("FAIL m3_data got rx=%h mosi=%h want beef", o_rx, o_mosi[15:0]); end
    n_cmp++; if (o_sclk_d !== 1'b1) begin
      n_err++; $display("FAIL m3_sclk_end got %b want 1", o_sclk_d); end
  endtask

  task automatic test_len32();
    miso_drv = 1'b1;
    run_xfer(2'b11, 32'hDEAD_BEEF, 1'b0, 1'b1, 8'd1, 1'b0, -5, 1'b0, 1'b0);
    n_cmp++; if (o_edges !== 64 || o_cs_low !== 130) begin
      n_err++; $display("FAIL l32_timing got edges=%0d cs=%0d want 64/130", o_edges, o_cs_low); end
    n_cmp++; if (o_mosi !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL l32_mosi got %h want deadbeef", o_mosi); end
    n_cmp++; if (o_rx !== o_miso) begin
      n_err++; $display("FAIL l32_rx got %h want %h", o_rx, o_miso); end
  endtask

  task automatic test_len24();
    run_xfer(2'b00, 32'hFF12_3456, 1'b0, 1'b0, 8'd0, 1'b1, -5, 1'b0, 1'b0);
    n_cmp++; if (o_edges !== 48 || o_rx !== 32'h0012_3456) begin
      n_err++; $display("FAIL l24 got edges=%0d rx=%h want 48/00123456", o_edges, o_rx); end
  endtask

  task automatic test_back_to_back();
    run_xfer(2'b10, 32'h0000_003C, 1'b0, 1'b0, 8'd1, 1'b1, 7, 1'b1, 1'b0);
    n_cmp++; if (o_done !== 1 || o_lat !== 35 || o_rx !== 32'h3C) begin
      n_err++; $display("FAIL b2b_first got n=%0d lat=%0d rx=%h want 1/35/3c", o_done, o_lat, o_rx); end
    @(negedge clk);
    n_cmp++; if (SPI_BUSY !== 1'b0 || SPI_CS_N !== 1'b1 || SPI_DONE !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle got busy=%b cs=%b done=%b want 0/1/0", SPI_BUSY, SPI_CS_N, SPI_DONE); end
    run_xfer(2'b01, 32'h0000_9A6C, 1'b0, 1'b1, 8'd0, 1'b1, -5, 1'b0, 1'b1);
    n_cmp++; if (o_done !== 1 || o_lat !== 34 || o_rx !== 32'h9A6C) begin
      n_err++; $display("FAIL b2b_second got n=%0d lat=%0d rx=%h want 1/34/9a6c", o_done, o_lat, o_rx); end
  endtask

  task automatic test_reset_mid();
    int edges, c;
    logic prev;
    logic [31:0] d;
    bit seen_done;
    d = $urandom;
    @(negedge clk);
    SPI_DATA_LEN = 2'b10; SPI_DATA_IN = d; SPI_CPOL = 1'b0; SPI_CPHA = 1'b0;
    SPI_CLK_DIV = 8'd1; loop_en = 1'b1;
    @(negedge clk);
    SPI_START = 1'b1; prev = SPI_SCLK; edges = 0; c = 0;
    while (edges < 5 && c < 100) begin
      @(negedge clk); SPI_START = 1'b0; c++;
      if (SPI_SCLK !== prev) edges++;
      prev = SPI_SCLK;
    end
    n_cmp++; if (edges !== 5) begin
      n_err++; $display("FAIL rmid_reach got edges=%0d want 5", edges); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({SPI_CS_N, SPI_SCLK, SPI_BUSY, SPI_DONE} !== 4'b1000) begin
      n_err++; $display("FAIL rmid_pins got %b want 1000", {SPI_CS_N, SPI_SCLK, SPI_BUSY, SPI_DONE}); end
    n_cmp++; if (SPI_RX_DATA !== 32'h0) begin
      n_err++; $display("FAIL rmid_rx got %h want 0", SPI_RX_DATA); end
    @(negedge clk); rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (SPI_DONE) seen_done = 1'b1;
    end
    n_cmp++; if (seen_done !== 1'b0 || SPI_BUSY !== 1'b0) begin
      n_err++; $display("FAIL rmid_nodone got done=%b busy=%b want 0/0", seen_done, SPI_BUSY); end
    run_xfer(2'b10, d, 1'b0, 1'b0, 8'd1, 1'b1, -5, 1'b0, 1'b0);
    n_cmp++; if (o_done !== 1 || o_rx !== {24'h0, d[7:0]}) begin
      n_err++; $display("FAIL rmid_after got n=%0d rx=%h want 1/%h", o_done, o_rx, {24'h0, d[7:0]}); end
  endtask

  task automatic test_max_div();
    run_xfer(2'b10, 32'h0000_0081, 1'b0, 1'b0, 8'd255, 1'b1, -5, 1'b0, 1'b0);
    n_cmp++; if (o_cs_low !== 17 * 256 || o_min_h !== 256 || o_rx !== 32'h81) begin
      n_err++; $display("FAIL maxdiv got cs=%0d half=%0d rx=%h want 4352/256/81", o_cs_low, o_min_h, o_rx); end
  endtask

  task automatic test_random();
    logic [1:0] l; logic [31:0] d; logic p, h, lp; logic [7:0] dv;
    int n, hh;
    for (int i = 0; i < 10; i++) begin
      l = 2'($urandom); d = $urandom; p = 1'($urandom); h = 1'($urandom);
      dv = 8'($urandom_range(0, 3)); lp = 1'($urandom);
      n = len_n(l); hh = int'(dv) + 1;
      run_xfer(l, d, p, h, dv, lp, -5, 1'b0, 1'b0);
      n_cmp++; if (o_cs_low !== (2 * n + 1) * hh || o_lat !== (2 * n + 1) * hh + 1 || o_edges !== 2 * n) begin
        n_err++; $display("FAIL rnd%0d_timing got cs=%0d lat=%0d edges=%0d want %0d/%0d/%0d", i,
                          o_cs_low, o_lat, o_edges, (2 * n + 1) * hh, (2 * n + 1) * hh + 1, 2 * n); end
      n_cmp++; if (low_bits(o_mosi, n) !== low_bits(d, n)) begin
        n_err++; $display("FAIL rnd%0d_mosi got %h want %h", i, low_bits(o_mosi, n), low_bits(d, n)); end
      n_cmp++; if (o_rx !== low_bits(o_miso, n) || (lp && o_rx !== low_bits(d, n))) begin
        n_err++; $display("FAIL rnd%0d_rx got %h want %h", i, o_rx, low_bits(o_miso, n)); end
      n_cmp++; if (o_mosi_d !== d[0] || o_sclk_d !== p || o_min_h !== hh || o_max_h !== hh) begin
        n_err++; $display("FAIL rnd%0d_misc got mosi=%b sclk=%b h=%0d/%0d want %b/%b/%0d", i,
                          o_mosi_d, o_sclk_d, o_min_h, o_max_h, d[0], p, hh); end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_len32();
    test_len24();
    test_back_to_back();
    test_reset_mid();
    test_max_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
SPI master serializer/deserializer. It sits directly downstream of the SPI bit-order stage and consumes that stage's already-ordered data word. On a start request it asserts chip select and generates SCLK for the programmed mode and rate. It shifts out the low N bits of the word on MOSI and captures N bits from MISO into a receive word, where N is selected by SPI_DATA_LEN.

Parameters:
DATA_WIDTH, 32, width of the TX and RX data words. Must be at least 32.
DIV_WIDTH, 8, width of SPI_CLK_DIV.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
SPI_START  input  1  single-cycle start request; honoured only when SPI_BUSY=0.
SPI_DATA_LEN  input  2  transfer length: 00=24 bits, 01=16, 10=8, 11=32.
SPI_DATA_IN  input  DATA_WIDTH  ordered TX word from the bit-order stage.
SPI_CPOL  input  1  SCLK idle level.
SPI_CPHA  input  1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
SPI_CLK_DIV  input  DIV_WIDTH  half-period of SCLK in clk cycles, minus 1.
SPI_MISO  input  1  serial data in.
SPI_SCLK  output  1  serial clock.
SPI_MOSI  output  1  serial data out.
SPI_CS_N  output  1  chip select, active low.
SPI_BUSY  output  1  high from the cycle after an accepted START through the DONE cycle.
SPI_DONE  output  1  one-cycle completion pulse.
SPI_RX_DATA  output  DATA_WIDTH  received word, right-aligned, upper bits zero.

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values (also applied immediately on reset mid-transfer):
  - SPI_SCLK=0, SPI_MOSI=0, SPI_CS_N=1, SPI_BUSY=0, SPI_DONE=0, SPI_RX_DATA=0.
  - FSM returns to IDLE. No DONE is produced for the aborted transfer.
- Config capture: on an accepted START, SPI_DATA_IN, N, SPI_CPOL, SPI_CPHA and SPI_CLK_DIV are latched. Input changes during the transfer have no effect.
- Bit order: bit [N-1] of the latched word is sent first, bit 0 last; bits above N-1 are ignored. Bit reversal is the upstream stage's job. RX shifts left, with MISO entering bit 0.
- Interval timing: let H = SPI_CLK_DIV+1. The transfer is 2N+1 consecutive intervals of H cycles each.
- FSM states: IDLE, LEAD, SHIFT, TRAIL, DONE.
  - IDLE: CS_N=1, SCLK=CPOL (tracks the live input), BUSY=0. START -> LEAD.
  - LEAD: one interval with CS_N=0 and SCLK at idle level. If CPHA=0, MOSI presents bit [N-1] from the first LEAD cycle. Exit -> SHIFT.
  - SHIFT: 2N SCLK edges. Edge k (k=1..2N) toggles SCLK at the end of interval k-1, i.e. the first edge coincides with the LEAD->SHIFT transition. Odd k is a leading edge, even k a trailing edge.
    - CPHA=0: sample MISO on leading edges; advance MOSI on trailing edges, except the last trailing edge.
    - CPHA=1: drive the next MOSI bit on leading edges (first bit on edge 1); sample MISO on trailing edges.
    - After edge 2N, SCLK is back at CPOL -> TRAIL.
  - TRAIL: one interval, CS_N=0, no SCLK edges. Exit -> DONE.
  - DONE: one cycle with CS_N=1, DONE=1, BUSY=1. SPI_RX_DATA is updated this cycle and held until the next DONE. -> IDLE.
- Total CS_N low time: (2N+1)·H cycles. START-to-DONE is (2N+1)·H+1 cycles.
- MOSI is held at its last value after the transfer and is not driven to 0.
- START while BUSY=1 is ignored, including in the DONE cycle. A new START is accepted in the first IDLE cycle.
- A bit counter of 6 bits is required to handle N=32.
- SPI_CLK_DIV=0 gives SCLK = clk/2, which must work.
- If SPI_CLK_DIV is at maximum, H=2^DIV_WIDTH with no overflow.

Test Plan:
1. Mode 0, DIV=0, LEN=10, DATA_IN=0x000000A5, MISO looped to MOSI:
   - MOSI bits 1,0,1,0,0,1,0,1.
   - CS_N low 17 cycles, 16 SCLK edges.
   - DONE 1 cycle, RX_DATA=0x000000A5.
2. Mode 3 (CPOL=1, CPHA=1), DIV=3, LEN=01, DATA_IN=0x1234BEEF, loopback:
   - SCLK idles high, each half-period is 4 cycles, CS_N low 132 cycles.
   - RX_DATA=0x0000BEEF.
3. LEN=11, DATA_IN=0xDEADBEEF, MISO held 1, mode 1, DIV=1:
   - 64 edges on SCLK.
   - RX_DATA=0xFFFFFFFF; MOSI stream equals 0xDEADBEEF MSB-first.
4. LEN=00, DATA_IN=0xFF123456, loopback:
   - Only 24 bits are sent.
   - RX_DATA=0x00123456.
5. START pulsed again mid-transfer, and again during the DONE cycle:
   - Both are ignored; exactly one DONE is produced.
   - A START in the following IDLE cycle launches a new transfer.
6. rst asserted at edge 5 of an 8-bit transfer, between clk edges:
   - CS_N=1, SCLK=0, BUSY=0 immediately, with no DONE.
   - RX_DATA=0.
   - After release, a new transfer completes correctly.
